// File: rtl/modulo_estoque_rolhas_pkg.sv
// modulo_estoque_rolhas_pkg: shared state encodings, default constants and stock width
package modulo_estoque_rolhas_pkg;
    localparam int W = 7;
    localparam int MAX_PADRAO = 99;
    localparam int LOTE_PADRAO = 15;
    localparam int LIMIAR_PADRAO = 5;
    localparam int TIMEOUT_PADRAO = 255;
    typedef enum logic [1:0] {
        ST_OCIOSO = 2'd0,
        ST_REPOR  = 2'd1,
        ST_ERRO   = 2'd2
    } estado_t;
endpackage

// File: rtl/modulo_estoque_rolhas_ajuste.sv
// modulo_ajuste_estoque: combinational decrement plus refill add, clamped to MAX_ROLHAS
module modulo_ajuste_estoque
    import modulo_estoque_rolhas_pkg::*;
#(
    parameter int MAX_ROLHAS = MAX_PADRAO
) (
    input  logic [W-1:0] estoque,
    input  logic         dec,
    input  logic [W-1:0] add,
    output logic [W-1:0] nxt
);
    logic [W:0] soma;
    // one extra bit so a refill near the ceiling is seen before the clamp
    assign soma = {1'b0, estoque} - {{W{1'b0}}, dec} + {1'b0, add};
    assign nxt  = (soma > (W+1)'(MAX_ROLHAS)) ? W'(MAX_ROLHAS) : soma[W-1:0];
endmodule

// File: rtl/modulo_estoque_rolhas.sv
// modulo_estoque_rolhas: cork stock controller with one-cork grants and watchdog-guarded refills
// Optional manual stock load is enabled by defining ESTOQUE_CARGA_MANUAL_EN.
module modulo_estoque_rolhas
    import modulo_estoque_rolhas_pkg::*;
#(
    parameter int MAX_ROLHAS     = MAX_PADRAO,
    parameter int LOTE_REPOSICAO = LOTE_PADRAO,
    parameter int LIMIAR_MINIMO  = LIMIAR_PADRAO,
    parameter int TIMEOUT_CICLOS = TIMEOUT_PADRAO
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         pedido_vedacao,
    output logic         vedacao_ack,
    output logic         reposicao_req,
    input  logic         reposicao_ack,
    output logic [W-1:0] estoque,
    output logic         falta_rolha,
    output logic         cheio,
    output logic         erro_reposicao
`ifdef ESTOQUE_CARGA_MANUAL_EN
    ,
    input  logic         carga_en,
    input  logic [W-1:0] carga_valor
`endif
);
    estado_t estado, estado_nxt;
    logic [7:0] cnt, cnt_nxt;
    logic grant, refill, carga;
    logic [W-1:0] ajustado, carga_sat;

`ifdef ESTOQUE_CARGA_MANUAL_EN
    assign carga     = carga_en;
    assign carga_sat = (carga_valor > W'(MAX_ROLHAS)) ? W'(MAX_ROLHAS) : carga_valor;
`else
    assign carga     = 1'b0;
    assign carga_sat = '0;
`endif

    // the ack register blocks back-to-back grants so a requester dropping on ack never double-consumes
    assign grant  = pedido_vedacao && (estoque != '0) && !vedacao_ack && !carga;
    assign refill = (estado == ST_REPOR) && reposicao_ack && !carga;

    modulo_ajuste_estoque #(.MAX_ROLHAS(MAX_ROLHAS)) u_ajuste (
        .estoque(estoque),
        .dec    (grant),
        .add    (refill ? W'(LOTE_REPOSICAO) : '0),
        .nxt    (ajustado)
    );

    always_comb begin
        estado_nxt = estado;
        cnt_nxt    = '0;
        if (estado == ST_OCIOSO)
            estado_nxt = (estoque <= W'(LIMIAR_MINIMO)) ? ST_REPOR : ST_OCIOSO;
        else if (estado == ST_REPOR) begin
            estado_nxt = refill ? ST_OCIOSO : (cnt == 8'(TIMEOUT_CICLOS)) ? ST_ERRO : ST_REPOR;
            cnt_nxt    = (refill || cnt == 8'(TIMEOUT_CICLOS)) ? '0 : cnt + 8'd1;
        end
        if (carga && estado != ST_ERRO) begin
            estado_nxt = ST_OCIOSO;
            cnt_nxt    = '0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            estado      <= ST_OCIOSO;
            cnt         <= '0;
            estoque     <= '0;
            vedacao_ack <= 1'b0;
        end else begin
            estado      <= estado_nxt;
            cnt         <= cnt_nxt;
            estoque     <= carga ? carga_sat : ajustado;
            vedacao_ack <= grant;
        end
    end

    assign reposicao_req  = (estado == ST_REPOR);
    assign erro_reposicao = (estado == ST_ERRO);
    assign falta_rolha    = (estoque == '0) && pedido_vedacao;
    assign cheio          = (estoque == W'(MAX_ROLHAS));
endmodule
